melody_recall_engine: RTL and testbench
=======================================

Name: melody_recall_engine

Overview:
Parametrised successor to the fixed 8-note reverse-recall game block. It plays a stored note sequence on the piezo and LEDs, growing one note per round. It then checks keypad recall in forward or reverse order, selected per game, and tolerates a configurable number of misses. It sits between the sequence/keypad front end and the piezo/LED drivers, and reports game end and win to the top-level game controller.

Parameters:
NOTE_W, 3, bits per stored note; tone code = note+1; 0 = silence
MAX_NOTES, 8, sequence depth; final round length
START_LEN, 3, notes in first round (1..MAX_NOTES)
TICK_DIV, 5000000, clk cycles per timing tick
ON_TICKS, 2, ticks a tone or key echo sounds
OFF_TICKS, 2, ticks of silence after each played note
MAX_MISSES, 3, misses that end the game (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
seq_data  in  MAX_NOTES*NOTE_W  note i at [i*NOTE_W +: NOTE_W]
seq_load  in  1  one-cycle strobe; captures seq_data
start  in  1  one-cycle strobe; starts a new game
reverse  in  1  recall order, sampled at start: 1 = last-to-first, 0 = first-to-last
key_valid  in  1  one-cycle pulse per key press
key_code  in  NOTE_W+1  pressed tone code
piezo_out  out  NOTE_W+1  tone code to the piezo driver
led_out  out  NOTE_W+1  tone code to the LED driver; always equals piezo_out
playing  out  1  high during playback and round gap
round_len  out  $clog2(MAX_NOTES+1)  current round length
misses  out  $clog2(MAX_MISSES+1)  misses this game
game_end  out  1  game over, held
game_win  out  1  game won, held

Behaviour:
- Reset (async, active-low):
  - All outputs and registers go to 0; state = IDLE; loaded flag cleared.
  - Mid-game reset silences outputs immediately.
- Tick counter:
  - Counts 0..TICK_DIV-1 and pulses tick at TICK_DIV-1.
  - Restarts at 0 on every state entry, so an N-tick state lasts exactly N*TICK_DIV cycles.
- States:
  - IDLE
    - Outputs 0.
    - seq_load sets loaded.
    - start with loaded: round_len = START_LEN, misses = 0, latch reverse, idx = 0, go to PLAY_ON.
    - start without loaded is ignored.
    - seq_load and start in the same cycle: the new data is used.
  - PLAY_ON
    - Outputs = seq[idx]+1 from the first cycle in the state.
    - After ON_TICKS ticks, go to PLAY_OFF.
  - PLAY_OFF
    - Outputs 0.
    - After OFF_TICKS ticks: if idx == round_len-1, go to WAIT_KEY with exp = reverse ? round_len-1 : 0 and cnt = 0; else idx+1, go to PLAY_ON.
  - WAIT_KEY
    - Outputs 0.
    - On key_valid: latch hit = (key_code == seq[exp]+1); outputs = key_code; go to KEY_ECHO.
    - key_code 0 or out of range counts as a miss.
  - KEY_ECHO
    - After ON_TICKS ticks, outputs go to 0, then:
      - hit and cnt < round_len-1: cnt+1; exp steps ±1 per mode; go to WAIT_KEY.
      - hit on the last note with round_len == MAX_NOTES: game_win = 1, go to DONE.
      - hit on the last note otherwise: round_len+1, go to ROUND_GAP.
      - miss with misses+1 == MAX_MISSES: misses+1, go to DONE with game_win = 0.
      - miss otherwise: misses+1, go to ROUND_GAP; the round replays at the same length from note 0.
  - ROUND_GAP
    - Outputs 0 for 2*OFF_TICKS ticks, then idx = 0, go to PLAY_ON.
  - DONE
    - game_end = 1; outputs 0.
    - seq_load accepted.
    - start begins a new game as in IDLE and clears game_end and game_win.
- key_valid is ignored in every state except WAIT_KEY; no queuing.
- start is ignored outside IDLE and DONE.
- seq_load is ignored outside IDLE and DONE.
- playing = 1 in PLAY_ON, PLAY_OFF and ROUND_GAP.
- round_len never exceeds MAX_NOTES; misses never exceeds MAX_MISSES.

Test Plan:
All scenarios use NOTE_W=3, MAX_NOTES=4, START_LEN=2, TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, MAX_MISSES=2. Notes are {3,5,0,6}.
1. Load, start with reverse=0 -> piezo = led = 4 for 8 cycles from the cycle after start, 0 for 4, 6 for 8, 0 for 4; then playing=0, round_len=2.
2. Forward keys 4 then 6 -> each echoed 8 cycles; round_len=3; 8 silent cycles; replay is 4, 6, 1.
3. Restart with reverse=1 at len 2: keys 6 then 4 -> round_len=3. Restart again, first key 4 -> misses=1 and len-2 replay.
4. A second miss -> game_end=1, game_win=0, outputs 0. A new start -> misses=0, round_len=2, playback restarts.
5. Correct recall through round_len=4 -> game_win=1, game_end=1, both held until the next start.
6. Negative cases:
   - key_valid during PLAY_ON or ROUND_GAP -> no state change.
   - start before any seq_load -> stays IDLE.
   - reset low mid PLAY_ON -> all outputs 0 immediately.
   - start after reset without a new load -> ignored.

Source files
------------

// File: rtl/melody_recall_engine.sv
`default_nettype none
// ============================================================================
//  Module   : melody_recall_engine
//  Purpose  : Plays a stored note sequence on the piezo/LED path. The melody
//             grows by one note each round. After each playback the engine
//             checks keypad recall, in forward or reverse order, and tolerates
//             a configurable number of misses before the game ends.
//  Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk        system clock
//    reset      asynchronous active-low reset
//    seq_data   packed note sequence, note i at [i*NOTE_W +: NOTE_W]
//    seq_load   strobe: capture seq_data (IDLE / DONE only)
//    start      strobe: begin a new game (IDLE / DONE, sequence loaded)
//    reverse    recall order sampled at start (1 = last-to-first)
//    key_valid  one-cycle key press pulse
//    key_code   pressed tone code
//    piezo_out  tone code to the piezo driver (0 = silence)
//    led_out    tone code to the LED driver (mirror of piezo_out)
//    playing    high during playback and the inter-round gap
//    round_len  current round length
//    misses     misses so far this game
//    game_end   game over, held until the next start
//    game_win   game won, held until the next start
// ============================================================================
module melody_recall_engine #(
    parameter int NOTE_W     = 3,
    parameter int MAX_NOTES  = 8,
    parameter int START_LEN  = 3,
    parameter int TICK_DIV   = 5000000,
    parameter int ON_TICKS   = 2,
    parameter int OFF_TICKS  = 2,
    parameter int MAX_MISSES = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [MAX_NOTES*NOTE_W-1:0]           seq_data,
    input  logic                                  seq_load,
    input  logic                                  start,
    input  logic                                  reverse,
    input  logic                                  key_valid,
    input  logic [NOTE_W:0]                       key_code,
    output logic [NOTE_W:0]                       piezo_out,
    output logic [NOTE_W:0]                       led_out,
    output logic                                  playing,
    output logic [$clog2(MAX_NOTES+1)-1:0]        round_len,
    output logic [$clog2(MAX_MISSES+1)-1:0]       misses,
    output logic                                  game_end,
    output logic                                  game_win
);

    localparam int c_lw = $clog2(MAX_NOTES + 1);
    localparam int c_iw = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int c_mw = $clog2(MAX_MISSES + 1);
    localparam int c_dw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_tw = 16;

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_play_on   = 3'd1;
    localparam logic [2:0] c_play_off  = 3'd2;
    localparam logic [2:0] c_wait_key  = 3'd3;
    localparam logic [2:0] c_key_echo  = 3'd4;
    localparam logic [2:0] c_round_gap = 3'd5;
    localparam logic [2:0] c_done      = 3'd6;

    logic [2:0]                  r_state;
    logic [2:0]                  w_next;
    logic [c_dw-1:0]             r_div;
    logic [c_tw-1:0]             r_ticks;
    logic [MAX_NOTES*NOTE_W-1:0] r_seq;
    logic                        r_loaded;
    logic [c_lw-1:0]             r_round_len;
    logic [c_mw-1:0]             r_misses;
    logic                        r_rev;
    logic [c_iw-1:0]             r_idx;
    logic [c_iw-1:0]             r_exp;
    logic [c_lw-1:0]             r_cnt;
    logic                        r_hit;
    logic [NOTE_W:0]             r_key;
    logic                        r_game_win;

    logic [NOTE_W-1:0]           w_notes [MAX_NOTES];
    logic [NOTE_W:0]             w_play_tone;
    logic [NOTE_W:0]             w_exp_tone;
    logic [c_lw-1:0]             w_len_m1;
    logic                        w_idx_last;
    logic                        w_cnt_last;
    logic                        w_full;
    logic                        w_last_miss;
    logic                        w_tick;
    logic                        w_on_done;
    logic                        w_off_done;
    logic                        w_gap_done;
    logic                        w_idle_like;
    logic                        w_start_ok;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_NOTES; gi++) begin : g_unpack
            assign w_notes[gi] = r_seq[gi*NOTE_W +: NOTE_W];
        end
    endgenerate

    assign w_play_tone = {1'b0, w_notes[r_idx]} + (NOTE_W+1)'(1);
    assign w_exp_tone  = {1'b0, w_notes[r_exp]} + (NOTE_W+1)'(1);
    assign w_len_m1    = r_round_len - c_lw'(1);
    assign w_idx_last  = (c_lw'(r_idx) == w_len_m1);
    assign w_cnt_last  = (r_cnt == w_len_m1);
    assign w_full      = (r_round_len == c_lw'(MAX_NOTES));
    assign w_last_miss = (r_misses == c_mw'(MAX_MISSES - 1));

    assign w_tick      = (r_div == c_dw'(TICK_DIV - 1));
    assign w_on_done   = w_tick && (r_ticks == c_tw'(ON_TICKS - 1));
    assign w_off_done  = w_tick && (r_ticks == c_tw'(OFF_TICKS - 1));
    assign w_gap_done  = w_tick && (r_ticks == c_tw'(2*OFF_TICKS - 1));

    assign w_idle_like = (r_state == c_idle) || (r_state == c_done);
    // A load in the same cycle as start is enough: the playback reads r_seq
    // only from the following cycle, by which time the new data is in place.
    assign w_start_ok  = start && (r_loaded || seq_load);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (w_start_ok) w_next = c_play_on;
            end
            c_play_on: begin
                if (w_on_done) w_next = c_play_off;
            end
            c_play_off: begin
                if (w_off_done) w_next = w_idx_last ? c_wait_key : c_play_on;
            end
            c_wait_key: begin
                if (key_valid) w_next = c_key_echo;
            end
            c_key_echo: begin
                if (w_on_done) begin
                    if (r_hit) begin
                        if (!w_cnt_last)  w_next = c_wait_key;
                        else if (w_full)  w_next = c_done;
                        else              w_next = c_round_gap;
                    end else begin
                        w_next = w_last_miss ? c_done : c_round_gap;
                    end
                end
            end
            c_round_gap: begin
                if (w_gap_done) w_next = c_play_on;
            end
            default: w_next = c_idle;
        endcase
    end

    // Output logic; decoded from state so reset silences outputs at once
    always_comb begin
        piezo_out = '0;
        case (r_state)
            c_play_on:  piezo_out = w_play_tone;
            c_key_echo: piezo_out = r_key;
            default:    piezo_out = '0;
        endcase
        led_out   = piezo_out;
        playing   = (r_state == c_play_on) || (r_state == c_play_off) ||
                    (r_state == c_round_gap);
        game_end  = (r_state == c_done);
        game_win  = r_game_win;
        round_len = r_round_len;
        misses    = r_misses;
    end

    // Tick divider and per-state tick count, both cleared on state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= '0;
            r_ticks <= '0;
        end else if (w_next != r_state) begin
            r_div   <= '0;
            r_ticks <= '0;
        end else if (w_tick) begin
            r_div   <= '0;
            r_ticks <= r_ticks + c_tw'(1);
        end else begin
            r_div   <= r_div + c_dw'(1);
        end
    end

    // Game datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq       <= '0;
            r_loaded    <= 1'b0;
            r_round_len <= '0;
            r_misses    <= '0;
            r_rev       <= 1'b0;
            r_idx       <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_hit       <= 1'b0;
            r_key       <= '0;
            r_game_win  <= 1'b0;
        end else begin
            if (seq_load && w_idle_like) begin
                r_seq    <= seq_data;
                r_loaded <= 1'b1;
            end
            case (r_state)
                c_idle, c_done: begin
                    if (w_start_ok) begin
                        r_round_len <= c_lw'(START_LEN);
                        r_misses    <= '0;
                        r_rev       <= reverse;
                        r_idx       <= '0;
                        r_game_win  <= 1'b0;
                    end
                end
                c_play_off: begin
                    if (w_off_done) begin
                        if (w_idx_last) begin
                            r_exp <= r_rev ? c_iw'(w_len_m1) : '0;
                            r_cnt <= '0;
                        end else begin
                            r_idx <= r_idx + c_iw'(1);
                        end
                    end
                end
                c_wait_key: begin
                    if (key_valid) begin
                        r_key <= key_code;
                        // Codes 0 and above the tone range never match.
                        r_hit <= (key_code == w_exp_tone);
                    end
                end
                c_key_echo: begin
                    if (w_on_done) begin
                        r_idx <= '0;
                        if (r_hit) begin
                            if (!w_cnt_last) begin
                                r_cnt <= r_cnt + c_lw'(1);
                                r_exp <= r_rev ? (r_exp - c_iw'(1)) : (r_exp + c_iw'(1));
                            end else if (w_full) begin
                                r_game_win <= 1'b1;
                            end else begin
                                r_round_len <= r_round_len + c_lw'(1);
                            end
                        end else begin
                            r_misses <= r_misses + c_mw'(1);
                        end
                    end
                end
                c_round_gap: begin
                    if (w_gap_done) r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_melody_recall_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_melody_recall_engine
//  Purpose  : Directed self-checking bench for melody_recall_engine
//             (NOTE_W=3, MAX_NOTES=4, START_LEN=2, TICK_DIV=4, ON_TICKS=2,
//             OFF_TICKS=1, MAX_MISSES=2, notes {3,5,0,6}).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_melody_recall_engine;

    localparam int NW = 3;
    localparam int MN = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [MN*NW-1:0] seq_data;
    logic             seq_load;
    logic             start;
    logic             reverse;
    logic             key_valid;
    logic [NW:0]      key_code;
    logic [NW:0]      piezo_out;
    logic [NW:0]      led_out;
    logic             playing;
    logic [2:0]       round_len;
    logic [1:0]       misses;
    logic             game_end;
    logic             game_win;

    int n_cmp  = 0;
    int n_fail = 0;

    // Tone codes of notes {3,5,0,6}
    logic [3:0] tones [4];

    always #5 clk = ~clk;

    melody_recall_engine #(
        .NOTE_W(3), .MAX_NOTES(4), .START_LEN(2), .TICK_DIV(4),
        .ON_TICKS(2), .OFF_TICKS(1), .MAX_MISSES(2)
    ) dut (
        .clk(clk), .reset(reset), .seq_data(seq_data), .seq_load(seq_load),
        .start(start), .reverse(reverse), .key_valid(key_valid),
        .key_code(key_code), .piezo_out(piezo_out), .led_out(led_out),
        .playing(playing), .round_len(round_len), .misses(misses),
        .game_end(game_end), .game_win(game_win)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check tone and playing for n cycles; optionally press a stray key in
    // the first cycle to show it is ignored.
    task automatic run(input string tag, input logic [3:0] tone, input int n,
                       input logic pl, input logic inject);
        for (int i = 0; i < n; i++) begin
            check({tag, "/piezo"},   32'(piezo_out), 32'(tone));
            check({tag, "/led"},     32'(led_out),   32'(tone));
            check({tag, "/playing"}, 32'(playing),   32'(pl));
            if (inject) begin
                key_valid = (i == 0);
                key_code  = 4'd7;
            end
            @(negedge clk);
        end
        if (inject) key_valid = 1'b0;
    endtask

    task automatic pulse_load();
        seq_data = 12'hC2B;   // note3=6, note2=0, note1=5, note0=3
        seq_load = 1'b1;
        @(negedge clk);
        seq_load = 1'b0;
    endtask

    task automatic pulse_start(input logic rev);
        reverse = rev;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic playback(input int n, input logic inject);
        for (int i = 0; i < n; i++) begin
            run("play_on", tones[i], 8, 1'b1, inject && (i == 0));
            run("play_off", 4'd0, 4, 1'b1, 1'b0);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        run("echo", k, 8, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        #1;
        check("rst/piezo",   32'(piezo_out), 0);
        check("rst/led",     32'(led_out),   0);
        check("rst/playing", 32'(playing),   0);
        check("rst/len",     32'(round_len), 0);
        check("rst/misses",  32'(misses),    0);
        check("rst/end",     32'(game_end),  0);
        check("rst/win",     32'(game_win),  0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tones     = '{4'd4, 4'd6, 4'd1, 4'd7};
        reset     = 1'b0;
        seq_data  = '0;
        seq_load  = 1'b0;
        start     = 1'b0;
        reverse   = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        repeat (2) @(negedge clk);
        check("init/piezo", 32'(piezo_out), 0);
        check("init/len",   32'(round_len), 0);
        check("init/end",   32'(game_end),  0);
        check("init/win",   32'(game_win),  0);
        reset = 1'b1;
        @(negedge clk);

        // Start before any load stays idle
        pulse_start(1'b0);
        run("noload", 4'd0, 6, 1'b0, 1'b0);
        check("noload/len", 32'(round_len), 0);

        // 1: forward game, first round
        pulse_load();
        pulse_start(1'b0);
        playback(2, 1'b0);
        check("t1/len", 32'(round_len), 2);

        // 2: forward recall, gap (stray key ignored), replay of 3 notes
        press(4'd4);
        press(4'd6);
        check("t2/len", 32'(round_len), 3);
        run("gap", 4'd0, 8, 1'b1, 1'b1);
        playback(3, 1'b1);
        check("t2/len_after", 32'(round_len), 3);

        // 3a: reverse recall succeeds
        do_reset();
        pulse_load();
        pulse_start(1'b1);
        playback(2, 1'b0);
        press(4'd6);
        press(4'd4);
        check("t3a/len",     32'(round_len), 3);
        check("t3a/playing", 32'(playing),   1);

        // 3b: reverse game, wrong first key
        do_reset();
        pulse_load();
        pulse_start(1'b1);
        playback(2, 1'b0);
        press(4'd4);
        check("t3b/misses", 32'(misses),    1);
        check("t3b/len",    32'(round_len), 2);
        run("gap", 4'd0, 8, 1'b1, 1'b0);
        playback(2, 1'b0);

        // 4: second miss ends the game
        press(4'd4);
        check("t4/end",    32'(game_end), 1);
        check("t4/win",    32'(game_win), 0);
        check("t4/misses", 32'(misses),   2);
        key_valid = 1'b1;
        key_code  = 4'd6;
        @(negedge clk);
        key_valid = 1'b0;
        run("done", 4'd0, 4, 1'b0, 1'b0);
        check("t4/end_held", 32'(game_end), 1);

        // 4/5: new game from DONE, forward recall to the full length
        pulse_start(1'b0);
        check("t5/misses", 32'(misses),    0);
        check("t5/len",    32'(round_len), 2);
        check("t5/end",    32'(game_end),  0);
        playback(2, 1'b0);
        press(4'd4); press(4'd6);
        run("gap", 4'd0, 8, 1'b1, 1'b0);
        playback(3, 1'b0);
        press(4'd4); press(4'd6); press(4'd1);
        check("t5/len4", 32'(round_len), 4);
        run("gap", 4'd0, 8, 1'b1, 1'b0);
        playback(4, 1'b0);
        press(4'd4); press(4'd6); press(4'd1); press(4'd7);
        check("t5/win", 32'(game_win), 1);
        check("t5/end", 32'(game_end), 1);
        run("won", 4'd0, 20, 1'b0, 1'b0);
        check("t5/win_held", 32'(game_win), 1);
        check("t5/end_held", 32'(game_end), 1);

        // Restart clears win, then reset mid PLAY_ON
        pulse_start(1'b0);
        check("t6/win_clr", 32'(game_win), 0);
        check("t6/end_clr", 32'(game_end), 0);
        run("t6_play", 4'd4, 3, 1'b1, 1'b0);
        do_reset();

        // Start after reset without reload is ignored
        pulse_start(1'b0);
        run("t6_noload", 4'd0, 6, 1'b0, 1'b0);
        check("t6/len", 32'(round_len), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
